// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB bus arbiter.
package sccb_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FAIL, GAP} sccbState_t;

  localparam logic [7:0] SLAVE_ADDR_DEF = 8'h42;
  localparam logic       ACK_OK         = 1'b0;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sccb_rr_grant.sv
// Two-port round-robin grant decoder: on a tie the port that did not win last time wins.
module sccb_rr_grant (
  input  logic [1:0] req,
  input  logic       lastGnt,
  output logic       gnt,
  output logic       gntVld
);

  assign gntVld = |req;
  assign gnt    = (req[0] & req[1]) ? ~lastGnt : req[1];

endmodule

// File: rtl/sccb_bus_arbiter.sv
// Shares one SCCB/I2C write controller between two requesters, with NACK retry,
// END timeout and an enforced bus gap between transactions.
module sccb_bus_arbiter
  import sccb_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR     = SLAVE_ADDR_DEF,
  parameter int         MAX_RETRY      = 3,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 2048
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iREQ0,
  input  logic [7:0]  iSUB0,
  input  logic [7:0]  iDAT0,
  output logic        oDONE0,
  output logic        oERR0,
  input  logic        iREQ1,
  input  logic [7:0]  iSUB1,
  input  logic [7:0]  iDAT1,
  output logic        oDONE1,
  output logic        oERR1,
  output logic [23:0] oI2C_DATA,
  output logic        oI2C_GO,
  input  logic        iI2C_END,
  input  logic        iI2C_ACK,
  output logic        oBUSY,
  output logic        oLAST_GNT
);

  // Retry counter must hold MAX_RETRY itself; gap/timeout only count to N-1.
  localparam int RW = cntWidth(MAX_RETRY + 1);
  localparam int GW = cntWidth(GAP_CYCLES);
  localparam int TW = cntWidth(TIMEOUT_CYCLES);

  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  sccbState_t    state, stateNext;
  logic [23:0]   word, wordNext;
  logic          go, goNext;
  logic          lastGnt, lastGntNext;
  logic          reissue, reissueNext;
  logic [1:0]    done, doneNext;
  logic [1:0]    err, errNext;
  logic [RW-1:0] retryCnt, retryNext;
  logic [GW-1:0] gapCnt, gapNext;
  logic [TW-1:0] tmoCnt, tmoNext;
  logic          gntPort, gntVld;

  sccb_rr_grant uGrant (
    .req     ({iREQ1, iREQ0}),
    .lastGnt (lastGnt),
    .gnt     (gntPort),
    .gntVld  (gntVld)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      word     <= '0;
      go       <= 1'b0;
      lastGnt  <= 1'b1;
      reissue  <= 1'b0;
      done     <= '0;
      err      <= '0;
      retryCnt <= '0;
      gapCnt   <= '0;
      tmoCnt   <= '0;
    end else begin
      state    <= stateNext;
      word     <= wordNext;
      go       <= goNext;
      lastGnt  <= lastGntNext;
      reissue  <= reissueNext;
      done     <= doneNext;
      err      <= errNext;
      retryCnt <= retryNext;
      gapCnt   <= gapNext;
      tmoCnt   <= tmoNext;
    end
  end

  always_comb begin
    stateNext   = state;
    wordNext    = word;
    goNext      = go;
    lastGntNext = lastGnt;
    reissueNext = reissue;
    doneNext    = '0;
    errNext     = '0;
    retryNext   = retryCnt;
    gapNext     = gapCnt;
    tmoNext     = tmoCnt;
    case (state)
      IDLE: begin
        if (gntVld) begin
          wordNext    = gntPort ? {SLAVE_ADDR, iSUB1, iDAT1} : {SLAVE_ADDR, iSUB0, iDAT0};
          lastGntNext = gntPort;
          retryNext   = '0;
          reissueNext = 1'b0;
          stateNext   = ISSUE;
        end
      end
      ISSUE: begin
        goNext    = 1'b1;
        tmoNext   = '0;
        stateNext = WAIT;
      end
      WAIT: begin
        tmoNext = tmoCnt + 1'b1;
        if (iI2C_END) begin
          goNext    = 1'b0;
          stateNext = CHECK;
        end else if (tmoCnt == TMO_LAST) begin
          goNext    = 1'b0;
          stateNext = FAIL;
        end
      end
      CHECK: begin
        gapNext = '0;
        if (iI2C_ACK == ACK_OK) begin
          doneNext[lastGnt] = 1'b1;
          reissueNext       = 1'b0;
          stateNext         = GAP;
        end else if (retryCnt != RETRY_MAX) begin
          retryNext   = retryCnt + 1'b1;
          reissueNext = 1'b1;
          stateNext   = GAP;
        end else begin
          stateNext = FAIL;
        end
      end
      FAIL: begin
        errNext[lastGnt] = 1'b1;
        reissueNext      = 1'b0;
        gapNext          = '0;
        stateNext        = GAP;
      end
      GAP: begin
        // END may linger until the controller notices GO low; never start over it.
        if (gapCnt != GAP_LAST) begin
          gapNext = gapCnt + 1'b1;
        end else if (!iI2C_END) begin
          stateNext = reissue ? ISSUE : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign oI2C_DATA = word;
  assign oI2C_GO   = go;
  assign oDONE0    = done[0];
  assign oDONE1    = done[1];
  assign oERR0     = err[0];
  assign oERR1     = err[1];
  assign oBUSY     = (state != IDLE);
  assign oLAST_GNT = lastGnt;

endmodule

// File: tb/tb_sccb_bus_arbiter.sv
// Directed bench for sccb_bus_arbiter with a behavioural SCCB controller responder.
module tb_sccb_bus_arbiter;

  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 2048;

  logic        iCLK, iRST_N;
  logic        iREQ0, iREQ1;
  logic [7:0]  iSUB0, iDAT0, iSUB1, iDAT1;
  logic        oDONE0, oERR0, oDONE1, oERR1;
  logic [23:0] oI2C_DATA;
  logic        oI2C_GO, oBUSY, oLAST_GNT;
  wire         iI2C_END;
  logic        iI2C_ACK;

  sccb_bus_arbiter #(
    .SLAVE_ADDR     (8'h42),
    .MAX_RETRY      (3),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iREQ0     (iREQ0),
    .iSUB0     (iSUB0),
    .iDAT0     (iDAT0),
    .oDONE0    (oDONE0),
    .oERR0     (oERR0),
    .iREQ1     (iREQ1),
    .iSUB1     (iSUB1),
    .iDAT1     (iDAT1),
    .oDONE1    (oDONE1),
    .oERR1     (oERR1),
    .oI2C_DATA (oI2C_DATA),
    .oI2C_GO   (oI2C_GO),
    .iI2C_END  (iI2C_END),
    .iI2C_ACK  (iI2C_ACK),
    .oBUSY     (oBUSY),
    .oLAST_GNT (oLAST_GNT)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int checks = 0;
  int failures = 0;

  // Controller model knobs
  int   nackLeft = 0;
  int   endDelay = 4;
  bit   endNever = 1'b0;
  bit   holdEnd  = 1'b0;
  logic endModel;
  assign iI2C_END = endModel | holdEnd;

  // Monitor counters
  int          goRises, goLen, goLowLen, lastLowLen, wordBad, bothCnt;
  int          done0Cnt, err0Cnt, done1Cnt, err1Cnt;
  logic [23:0] firstWord;
  logic        prevGo;

  typedef struct {
    int          port;
    logic [7:0]  sub;
    logic [7:0]  dat;
    int          nacks;
    int          delay;
    bit          never;
    int          expGo;
    int          expDone;
    int          expErr;
    int          expLen;
    logic [23:0] expData;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic clearCounts();
    goRises = 0; goLen = 0; goLowLen = 0; lastLowLen = 0; wordBad = 0; bothCnt = 0;
    done0Cnt = 0; err0Cnt = 0; done1Cnt = 0; err1Cnt = 0; firstWord = '0;
  endtask

  task automatic setReq(input int port, input bit val, input logic [7:0] sub, input logic [7:0] dat);
    if (port == 0) begin
      iREQ0 = val; iSUB0 = sub; iDAT0 = dat;
    end else begin
      iREQ1 = val; iSUB1 = sub; iDAT1 = dat;
    end
  endtask

  task automatic dropReq(input int port);
    if (port == 0) iREQ0 = 1'b0;
    else iREQ1 = 1'b0;
  endtask

  task automatic waitPort(input string name, input int port);
    bit seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      step(1);
      seen = (port == 0) ? (oDONE0 | oERR0) : (oDONE1 | oERR1);
    end
    check({name, "_pulse_seen"}, int'(seen), 1);
  endtask

  task automatic waitIdle(input string name);
    for (int c = 0; c < 200 && oBUSY; c++) step(1);
    check({name, "_idle"}, int'(oBUSY), 0);
  endtask

  // Behavioural controller: END after endDelay GO-high cycles, held until GO drops.
  initial begin
    int cnt;
    endModel = 1'b0;
    iI2C_ACK = 1'b0;
    cnt = 0;
    forever begin
      @(posedge iCLK);
      #2;
      if (!iRST_N || !oI2C_GO) begin
        endModel = 1'b0;
        cnt = 0;
      end else if (!endNever && !endModel) begin
        cnt++;
        if (cnt >= endDelay) begin
          endModel = 1'b1;
          iI2C_ACK = (nackLeft > 0);
          if (nackLeft > 0) nackLeft--;
        end
      end
    end
  end

  initial begin
    prevGo = 1'b0;
    forever begin
      @(negedge iCLK);
      if (oDONE0) done0Cnt++;
      if (oERR0)  err0Cnt++;
      if (oDONE1) done1Cnt++;
      if (oERR1)  err1Cnt++;
      if ((oDONE0 && oERR0) || (oDONE1 && oERR1)) bothCnt++;
      if (oI2C_GO && !prevGo) begin
        goRises++;
        if (goRises == 1) firstWord = oI2C_DATA;
        else if (oI2C_DATA != firstWord) wordBad++;
        goLen = 0;
        lastLowLen = goLowLen;
        goLowLen = 0;
      end
      if (oI2C_GO) goLen++;
      else goLowLen++;
      prevGo = oI2C_GO;
    end
  end

  initial begin
    vecs[0] = '{0, 8'h12, 8'h14, 0, 10, 1'b0, 1, 1, 0, 10,             24'h421214};
    vecs[1] = '{1, 8'hA5, 8'h3C, 2, 5,  1'b0, 3, 1, 0, 5,              24'h42A53C};
    vecs[2] = '{0, 8'h01, 8'hFF, 9, 3,  1'b0, 4, 0, 1, 3,              24'h4201FF};
    vecs[3] = '{1, 8'h00, 8'h00, 0, 1,  1'b0, 1, 1, 0, 1,              24'h420000};
    vecs[4] = '{0, 8'h80, 8'h7F, 3, 2,  1'b0, 4, 1, 0, 2,              24'h42807F};
    vecs[5] = '{1, 8'h5A, 8'hC3, 0, 1,  1'b1, 1, 0, 1, TIMEOUT_CYCLES, 24'h425AC3};

    iRST_N = 1'b0;
    iREQ0 = 1'b0; iSUB0 = '0; iDAT0 = '0;
    iREQ1 = 1'b0; iSUB1 = '0; iDAT1 = '0;
    clearCounts();
    step(3);
    check("rst_go",    int'(oI2C_GO),   0);
    check("rst_data",  int'(oI2C_DATA), 0);
    check("rst_busy",  int'(oBUSY),     0);
    check("rst_last",  int'(oLAST_GNT), 1);
    check("rst_pulse", int'({oDONE0, oERR0, oDONE1, oERR1}), 0);
    iRST_N = 1'b1;
    step(2);

    // Simultaneous requests right after reset: port 0 first, then port 1
    clearCounts();
    nackLeft = 0; endDelay = 4; endNever = 1'b0;
    setReq(0, 1'b1, 8'h12, 8'h14);
    setReq(1, 1'b1, 8'h34, 8'h56);
    step(1);
    check("tie_first_gnt",  int'(oLAST_GNT), 0);
    check("tie_first_data", int'(oI2C_DATA), 32'h421214);
    waitPort("tie_p0", 0);
    dropReq(0);
    check("tie_p1_not_yet", done1Cnt, 0);
    waitPort("tie_p1", 1);
    dropReq(1);
    waitIdle("tie");
    check("tie_second_gnt",  int'(oLAST_GNT), 1);
    check("tie_second_data", int'(oI2C_DATA), 32'h423456);
    check("tie_done0",       done0Cnt, 1);
    check("tie_done1",       done1Cnt, 1);
    check("tie_go_count",    goRises, 2);
    check("tie_gap_min",     int'(lastLowLen >= GAP_CYCLES), 1);

    foreach (vecs[i]) begin
      clearCounts();
      nackLeft = vecs[i].nacks;
      endDelay = vecs[i].delay;
      endNever = vecs[i].never;
      setReq(vecs[i].port, 1'b1, vecs[i].sub, vecs[i].dat);
      step(1);
      check($sformatf("v%0d_grant_busy", i), int'(oBUSY), 1);
      check($sformatf("v%0d_go_not_yet", i), int'(oI2C_GO), 0);
      check($sformatf("v%0d_data", i), int'(oI2C_DATA), int'(vecs[i].expData));
      check($sformatf("v%0d_last_gnt", i), int'(oLAST_GNT), vecs[i].port);
      step(1);
      check($sformatf("v%0d_go_rise", i), int'(oI2C_GO), 1);
      waitPort($sformatf("v%0d", i), vecs[i].port);
      dropReq(vecs[i].port);
      endNever = 1'b0;
      waitIdle($sformatf("v%0d", i));
      check($sformatf("v%0d_go_count", i), goRises, vecs[i].expGo);
      check($sformatf("v%0d_go_len", i), goLen, vecs[i].expLen);
      check($sformatf("v%0d_done", i), (vecs[i].port == 0) ? done0Cnt : done1Cnt, vecs[i].expDone);
      check($sformatf("v%0d_err", i), (vecs[i].port == 0) ? err0Cnt : err1Cnt, vecs[i].expErr);
      check($sformatf("v%0d_other_port", i),
            (vecs[i].port == 0) ? (done1Cnt + err1Cnt) : (done0Cnt + err0Cnt), 0);
      check($sformatf("v%0d_same_word", i), wordBad, 0);
      check($sformatf("v%0d_done_err_both", i), bothCnt, 0);
    end

    // Port 0 always NACKed while port 1 waits; lastGnt=1 so port 0 wins the tie
    clearCounts();
    nackLeft = 4; endDelay = 3;
    setReq(0, 1'b1, 8'h01, 8'hFF);
    setReq(1, 1'b1, 8'h22, 8'h33);
    step(1);
    check("nack_first_gnt", int'(oLAST_GNT), 0);
    waitPort("nack_p0", 0);
    check("nack_err_pulse", int'(oERR0), 1);
    dropReq(0);
    check("nack_go_count", goRises, 4);
    waitPort("nack_p1", 1);
    dropReq(1);
    waitIdle("nack");
    check("nack_err0",  err0Cnt, 1);
    check("nack_done0", done0Cnt, 0);
    check("nack_done1", done1Cnt, 1);
    check("nack_err1",  err1Cnt, 0);
    check("nack_last",  int'(oLAST_GNT), 1);

    // Timeout, then END held high through the gap blocks the next grant
    clearCounts();
    nackLeft = 0; endDelay = 2; endNever = 1'b1;
    setReq(0, 1'b1, 8'h44, 8'h55);
    setReq(1, 1'b1, 8'h66, 8'h77);
    waitPort("tmo_p0", 0);
    check("tmo_err_pulse", int'(oERR0), 1);
    check("tmo_go_len", goLen, TIMEOUT_CYCLES);
    holdEnd = 1'b1;
    endNever = 1'b0;
    dropReq(0);
    step(12);
    check("tmo_hold_busy", int'(oBUSY), 1);
    check("tmo_hold_no_go", goRises, 1);
    check("tmo_hold_last", int'(oLAST_GNT), 0);
    holdEnd = 1'b0;
    waitPort("tmo_p1", 1);
    dropReq(1);
    waitIdle("tmo");
    check("tmo_err0",  err0Cnt, 1);
    check("tmo_done1", done1Cnt, 1);
    check("tmo_go_count", goRises, 2);
    check("tmo_last", int'(oLAST_GNT), 1);

    // Reset while waiting for END
    clearCounts();
    endNever = 1'b1;
    setReq(0, 1'b1, 8'h9A, 8'hBC);
    for (int c = 0; c < 20 && !oI2C_GO; c++) step(1);
    check("rstw_go_started", int'(oI2C_GO), 1);
    step(3);
    iRST_N = 1'b0;
    #1;
    check("rstw_go_async", int'(oI2C_GO), 0);
    check("rstw_busy",     int'(oBUSY), 0);
    check("rstw_last",     int'(oLAST_GNT), 1);
    check("rstw_data",     int'(oI2C_DATA), 0);
    step(2);
    check("rstw_no_pulse", done0Cnt + err0Cnt, 0);
    endNever = 1'b0;
    endDelay = 2;
    iRST_N = 1'b1;
    waitPort("rstw_p0", 0);
    check("rstw_regrant", int'(oLAST_GNT), 0);
    dropReq(0);
    waitIdle("rstw");
    check("rstw_done0", done0Cnt, 1);
    check("rstw_err0",  err0Cnt, 0);
    check("rstw_data_after", int'(oI2C_DATA), 32'h429ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
